// File: rtl/mem_map_pkg.sv
// Shared definitions for the memory-map controller: region nibbles,
// fetch/load mux encodings, the IO handshake state type and decode helpers.
package mem_map_pkg;

  // Upper-address-nibble region codes
  localparam logic [3:0] DMEM_NIB = 4'b0001;
  localparam logic [3:0] IMEM_NIB = 4'b0010;
  localparam logic [3:0] DUAL_NIB = 4'b0011;
  localparam logic [3:0] BIOS_NIB = 4'b0100;
  localparam logic [3:0] IO_NIB   = 4'b1000;

  // Fetch mux encodings
  localparam logic [1:0] ILSEL_IMEM = 2'd0;
  localparam logic [1:0] ILSEL_BIOS = 2'd1;
  localparam logic [1:0] ILSEL_INV  = 2'd2;

  // W-stage load mux encodings
  localparam logic [1:0] DLSEL_DMEM = 2'd0;
  localparam logic [1:0] DLSEL_BIOS = 2'd1;
  localparam logic [1:0] DLSEL_IO   = 2'd2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    IO_WAIT = 2'd1,
    IO_DONE = 2'd2
  } io_state_t;

  // Load mux select for a data-address nibble; unmapped regions fall back to DMEM
  function automatic logic [1:0] dload_decode(input logic [3:0] nib);
    logic [1:0] sel;
    case (nib)
      DMEM_NIB, DUAL_NIB: sel = DLSEL_DMEM;
      BIOS_NIB:           sel = DLSEL_BIOS;
      IO_NIB:             sel = DLSEL_IO;
      default:            sel = DLSEL_DMEM;
    endcase
    return sel;
  endfunction

  // True when the nibble belongs to any defined region
  function automatic logic nib_mapped(input logic [3:0] nib);
    logic hit;
    case (nib)
      DMEM_NIB, IMEM_NIB, DUAL_NIB, BIOS_NIB, IO_NIB: hit = 1'b1;
      default:                                        hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/mem_map_ctrl_io_handshake_fsm.sv
// IO request/acknowledge handshake: issues io_req for an M-stage IO access,
// freezes the pipeline until io_ack or a timeout, and parks in IO_DONE while
// another source still holds the pipeline so the access is never re-issued.
module io_handshake_fsm
  import mem_map_pkg::*;
#(
  parameter int IO_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic io_access_i,
  input  logic io_store_i,
  input  logic io_ack_i,
  input  logic ext_stall_i,
  output logic io_req_o,
  output logic io_we_o,
  output logic stall_o,
  output logic io_timeout_o
);

  localparam logic [7:0] CNT_LAST = 8'(IO_TIMEOUT - 1);

  io_state_t  state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       we_q, we_d;
  logic       req, we, stl, tmo;

  // State, wait counter and latched store flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 8'd0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
    end
  end

  // Next-state and handshake outputs; ack takes precedence over timeout
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    req     = 1'b0;
    we      = 1'b0;
    stl     = 1'b0;
    tmo     = 1'b0;
    case (state_q)
      IDLE: begin
        if (io_access_i) begin
          req     = 1'b1;
          we      = io_store_i;
          stl     = 1'b1;
          we_d    = io_store_i;
          cnt_d   = 8'd0;
          state_d = IO_WAIT;
        end
      end
      IO_WAIT: begin
        req   = 1'b1;
        we    = we_q;
        stl   = 1'b1;
        cnt_d = cnt_q + 8'd1;
        if (io_ack_i) begin
          stl     = 1'b0;
          state_d = ext_stall_i ? IO_DONE : IDLE;
        end else if (cnt_q == CNT_LAST) begin
          stl     = 1'b0;
          tmo     = 1'b1;
          state_d = ext_stall_i ? IO_DONE : IDLE;
        end
      end
      IO_DONE: begin
        if (!ext_stall_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A reset abandons any transaction at once, even with the access still presented
  assign io_req_o     = req & rst_n;
  assign io_we_o      = we & rst_n;
  assign stall_o      = stl & rst_n;
  assign io_timeout_o = tmo & rst_n;

endmodule

// File: rtl/mem_map_ctrl.sv
// Memory-map controller: region store enables, fetch/load mux selects,
// registered W-stage load select and the stalling IO handshake.
// Optional access-fault monitor enabled by defining ACCESS_FAULT_EN.
module mem_map_ctrl
  import mem_map_pkg::*;
#(
  parameter int WE_W       = 4,
  parameter int IO_TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [3:0]      pc_upper_f,
  input  logic [3:0]      pc_upper_m,
  input  logic [3:0]      adr_upper_m,
  input  logic [WE_W-1:0] we_m,
  input  logic            re_m,
  input  logic            ext_stall,
  output logic [WE_W-1:0] iwea,
  output logic [WE_W-1:0] dwea,
  output logic [1:0]      iload_sel,
  output logic [1:0]      dload_sel,
  output logic            io_req,
  output logic            io_we,
  input  logic            io_ack,
  output logic            stall,
  output logic            io_timeout,
  output logic            fault,
  input  logic            fault_clr
);

  logic       any_we;
  logic       io_access;
  logic [1:0] dload_q, dload_d;

  assign any_we    = |we_m;
  assign io_access = (adr_upper_m == IO_NIB) & (re_m | any_we);

  io_handshake_fsm #(
    .IO_TIMEOUT(IO_TIMEOUT)
  ) u_io_fsm (
    .clk         (clk),
    .rst_n       (rst_n),
    .io_access_i (io_access),
    .io_store_i  (any_we),
    .io_ack_i    (io_ack),
    .ext_stall_i (ext_stall),
    .io_req_o    (io_req),
    .io_we_o     (io_we),
    .stall_o     (stall),
    .io_timeout_o(io_timeout)
  );

  // Store enables; IMEM writes only while the storing instruction runs from BIOS
  always_comb begin
    dwea = '0;
    iwea = '0;
    case (adr_upper_m)
      DMEM_NIB: dwea = we_m;
      DUAL_NIB: begin
        dwea = we_m;
        if (pc_upper_m == BIOS_NIB) iwea = we_m;
      end
      IMEM_NIB: begin
        if (pc_upper_m == BIOS_NIB) iwea = we_m;
      end
      default: begin
        dwea = '0;
        iwea = '0;
      end
    endcase
    if (stall) begin
      dwea = '0;
      iwea = '0;
    end
  end

  // Fetch source for the F-stage PC
  always_comb begin
    case (pc_upper_f)
      DMEM_NIB: iload_sel = ILSEL_IMEM;
      BIOS_NIB: iload_sel = ILSEL_BIOS;
      default:  iload_sel = ILSEL_INV;
    endcase
  end

  assign dload_d = dload_decode(adr_upper_m);

  // W-stage load select advances with the pipeline only
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dload_q <= DLSEL_DMEM;
    end else if (!(stall | ext_stall)) begin
      dload_q <= dload_d;
    end
  end

  assign dload_sel = dload_q;

`ifdef ACCESS_FAULT_EN
  logic fault_q;
  logic fault_set;

  assign fault_set = ((adr_upper_m == BIOS_NIB) & any_we)
                   | (~nib_mapped(adr_upper_m) & (re_m | any_we))
                   | (iload_sel == ILSEL_INV)
                   | io_timeout;

  // Sticky fault flag; a new fault outranks a simultaneous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_q <= 1'b0;
    end else if (fault_set) begin
      fault_q <= 1'b1;
    end else if (fault_clr) begin
      fault_q <= 1'b0;
    end
  end

  assign fault = fault_q;
`else
  logic unused_fault_clr;
  assign unused_fault_clr = fault_clr;
  assign fault            = 1'b0;
`endif

endmodule

// File: doc/mem_map_ctrl.md
Name: mem_map_ctrl

Overview:
- Memory-map controller for the 3-stage RISC-V core; successor to the fixed-decode store-mask/load-mux block.
- Decodes the upper address nibble into per-region write enables (IMEM, DMEM, BIOS, IO) and fetch/load mux selects, with the W-stage select registered.
- Adds a stalling IO request/acknowledge handshake with a timeout.
- Adds an optional access-fault monitor.

Parameters:
- DMEM_NIB, 4'b0001, nibble for data memory only.
- IMEM_NIB, 4'b0010, nibble for instruction memory (store-only; stores honoured only while executing from BIOS).
- DUAL_NIB, 4'b0011, nibble that aliases IMEM and DMEM.
- BIOS_NIB, 4'b0100, nibble for BIOS ROM (fetch/read-only).
- IO_NIB, 4'b1000, nibble for the memory-mapped IO space.
- WE_W, 4, byte-write-enable width.
- IO_TIMEOUT, 16, maximum IO_WAIT cycles before forced release; legal range 2..255.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- pc_upper_f  in  4  PC[31:28] of the F-stage instruction (true PC, not PC+4)
- pc_upper_m  in  4  PC[31:28] of the M-stage instruction
- adr_upper_m  in  4  data address[31:28] in M
- we_m  in  WE_W  byte write enables in M
- re_m  in  1  load in M
- ext_stall  in  1  pipeline held by another source
- iwea  out  WE_W  IMEM byte enables
- dwea  out  WE_W  DMEM byte enables
- iload_sel  out  2  fetch mux: 0 IMEM, 1 BIOS, 2 invalid
- dload_sel  out  2  W-stage load mux: 0 DMEM, 1 BIOS, 2 IO (registered)
- io_req  out  1  IO request, held until acknowledged
- io_we  out  1  IO request is a store (valid while io_req is high)
- io_ack  in  1  IO completion
- stall  out  1  pipeline freeze request
- io_timeout  out  1  one-cycle pulse on forced release
- fault  out  1  sticky access fault (see Optional Feature)
- fault_clr  in  1  clears fault

Behaviour:
- Reset (async, rst_n=0): state=IDLE, timeout counter=0, dload_sel=0, fault=0, io_timeout=0. Combinational outputs follow their inputs.
- Store decode (combinational):
  - DMEM_NIB or DUAL_NIB -> dwea=we_m.
  - IMEM_NIB or DUAL_NIB, and pc_upper_m==BIOS_NIB -> iwea=we_m.
  - All other cases force the enable to 0. No latch; every path assigns every enable.
- Fetch decode: pc_upper_f==DMEM_NIB -> iload_sel 0; BIOS_NIB -> 1; anything else -> 2.
- Load select:
  - Next value from adr_upper_m: DMEM/DUAL -> 0, BIOS -> 1, IO -> 2, other -> 0.
  - Registered on posedge when !(stall|ext_stall); otherwise held.
- io_access = (adr_upper_m==IO_NIB) & (re_m | |we_m).
- FSM states IDLE, IO_WAIT, IO_DONE:
  - IDLE & io_access: io_req=1, io_we=|we_m, stall=1; next state IO_WAIT; counter cleared. io_ack is ignored in IDLE.
  - IO_WAIT: io_req held, stall=1, counter increments each cycle.
    - io_ack=1 & !ext_stall: stall=0 in the same cycle; next IDLE.
    - io_ack=1 & ext_stall: next IO_DONE.
    - counter==IO_TIMEOUT-1 without ack: stall=0, io_timeout pulses, next IDLE (IO_DONE if ext_stall).
  - IO_DONE: io_req=0, stall=0; stays until ext_stall=0, then next IDLE. Never re-issues the same access.
- Minimum IO latency is 2 cycles (request cycle plus one wait).
- Simultaneous ack and timeout: the ack wins and io_timeout is not pulsed.
- Reset mid-handshake: io_req drops immediately and the transaction is abandoned.
- During IO stalls iwea and dwea are forced to 0.

Optional Feature:
- Macro ACCESS_FAULT_EN.
- Defined:
  - fault sets on any of: a store to BIOS_NIB; an access (load or store) to an unmapped nibble; iload_sel==2; a timeout.
  - Stays set until fault_clr. Set has priority over a simultaneous clear.
- Undefined: fault tied 0, fault_clr ignored; illegal stores are silently dropped.

Decomposition:
- Package mem_map_pkg:
  - region nibble constants;
  - iload encodings ILSEL_IMEM/ILSEL_BIOS/ILSEL_INV;
  - dload encodings DLSEL_DMEM/DLSEL_BIOS/DLSEL_IO;
  - FSM state enum io_state_t.
- Sub-module io_handshake_fsm: FSM, timeout counter, io_req/io_we/stall/io_timeout generation.
- Decode logic and the dload register stay in the top level.

Test Plan:
- pc_upper_m=4'b0100, adr=4'b0011, we_m=4'b1111 -> iwea=4'b1111, dwea=4'b1111; repeat with pc_upper_m=4'b0001 -> iwea=0, dwea=4'b1111.
- pc_upper_f swept over 0001/0100/0010 -> iload_sel 0/1/2.
- IO store at adr 4'b1000, io_ack asserted in the 3rd cycle -> io_req high for 3 cycles, stall high for 2 then low in the ack cycle, io_we=1, state back to IDLE.
- IO load, io_ack never asserted, IO_TIMEOUT=16 -> stall released after 16 cycles, io_timeout pulses once, dload_sel=2 on the next update.
- io_ack with ext_stall=1 for 3 cycles -> IO_DONE, no second io_req, stall=0 throughout, IDLE once ext_stall drops.
- ACCESS_FAULT_EN: store to 4'b0100 -> dwea=iwea=0 and fault=1. fault_clr then clears it; fault_clr together with a new fault keeps fault=1. rst_n pulsed during IO_WAIT -> io_req=0 at once.
